rab_inv_seq: RTL

// Range-invalidation sequencer for the RAB translation tables. A config-side write of an

---
 rtl/rab_inv_if.sv | 49 ++++
 rtl/rab_inv_seq.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/rab_inv_if.sv
// Handshake and table-access bundle between the config side, the RAB tables and the
// range-invalidation sequencer. The slave modport is the sequencer.
`timescale 1ns/1ps
interface rab_inv_if #(
  parameter int unsigned AW               = 32,
  parameter int unsigned N_L1_SLICES      = 32,
  parameter int unsigned L2_N_SETS        = 32,
  parameter int unsigned L2_N_SET_ENTRIES = 32,
  parameter int unsigned PAGE_BITS        = 12
);
  localparam int unsigned L1_IW = (N_L1_SLICES > 1) ? $clog2(N_L1_SLICES) : 1;
  localparam int unsigned SET_W = (L2_N_SETS > 1) ? $clog2(L2_N_SETS) : 1;
  localparam int unsigned ENT_W = (L2_N_SET_ENTRIES > 1) ? $clog2(L2_N_SET_ENTRIES) : 1;
  localparam int unsigned VPN_W = AW - PAGE_BITS;

  logic             req;
  logic [AW-1:0]    inv_min;
  logic [AW-1:0]    inv_max;
  logic             ack_c;
  logic             busy;
  logic             done;
  logic             cfg_block;

  logic [L1_IW-1:0] l1_idx;
  logic             l1_rd;
  logic [AW-1:0]    l1_va_start;
  logic [AW-1:0]    l1_va_end;
  logic             l1_en;
  logic             l1_clr_c;

  logic [SET_W-1:0] l2_set;
  logic [ENT_W-1:0] l2_ent;
  logic             l2_rd;
  logic [VPN_W-1:0] l2_vpn;
  logic             l2_valid;
  logic             l2_clr_c;

  modport master (
    output req, inv_min, inv_max, l1_va_start, l1_va_end, l1_en, l2_vpn, l2_valid,
    input  ack_c, busy, done, cfg_block, l1_idx, l1_rd, l1_clr_c,
           l2_set, l2_ent, l2_rd, l2_clr_c
  );

  modport slave (
    input  req, inv_min, inv_max, l1_va_start, l1_va_end, l1_en, l2_vpn, l2_valid,
    output ack_c, busy, done, cfg_block, l1_idx, l1_rd, l1_clr_c,
           l2_set, l2_ent, l2_rd, l2_clr_c
  );
endinterface

// File: rtl/rab_inv_seq.sv
// Range-invalidation sequencer: walks every L1 slice and every L2 set/entry, clearing
// each enabled/valid entry that overlaps the latched [min, max] range.
`timescale 1ns/1ps
module rab_inv_seq #(
  parameter int unsigned AW               = 32,
  parameter int unsigned N_L1_SLICES      = 32,
  parameter int unsigned L2_N_SETS        = 32,
  parameter int unsigned L2_N_SET_ENTRIES = 32,
  parameter int unsigned PAGE_BITS        = 12
) (
  input  logic     clk,
  input  logic     rst_n,
  rab_inv_if.slave bus
);
  localparam int unsigned L1_IW = (N_L1_SLICES > 1) ? $clog2(N_L1_SLICES) : 1;
  localparam int unsigned SET_W = (L2_N_SETS > 1) ? $clog2(L2_N_SETS) : 1;
  localparam int unsigned ENT_W = (L2_N_SET_ENTRIES > 1) ? $clog2(L2_N_SET_ENTRIES) : 1;

  localparam logic [L1_IW-1:0] L1_LAST  = L1_IW'(N_L1_SLICES - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(L2_N_SETS - 1);
  localparam logic [ENT_W-1:0] ENT_LAST = ENT_W'(L2_N_SET_ENTRIES - 1);

  typedef enum logic [2:0] {IDLE, L1_RD, L1_CHK, L2_RD, L2_CHK, FIN} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    min_q, min_d;
  logic [AW-1:0]    max_q, max_d;
  logic [L1_IW-1:0] l1_idx_q, l1_idx_d;
  logic [SET_W-1:0] l2_set_q, l2_set_d;
  logic [ENT_W-1:0] l2_ent_q, l2_ent_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             l1_rd_q, l1_rd_d;
  logic             l2_rd_q, l2_rd_d;

  logic             l1_hit;
  logic             l2_hit;
  logic [AW-1:0]    l2_base;
  logic [AW:0]      l2_last;

  // Overlap tests; the L2 page end is one bit wider so the top page cannot wrap.
  assign l2_base = {bus.l2_vpn, {PAGE_BITS{1'b0}}};
  assign l2_last = {1'b0, l2_base} + (AW+1)'({PAGE_BITS{1'b1}});
  assign l1_hit  = bus.l1_en && (bus.l1_va_start <= max_q) && (bus.l1_va_end >= min_q);
  assign l2_hit  = bus.l2_valid && (l2_base <= max_q) && (l2_last >= {1'b0, min_q});

  // Table read data only arrives in the CHK cycle, so clears and ready are combinational.
  assign bus.ack_c    = (state_q == IDLE) && bus.req;
  assign bus.l1_clr_c = (state_q == L1_CHK) && l1_hit;
  assign bus.l2_clr_c = (state_q == L2_CHK) && l2_hit;

  assign bus.busy      = busy_q;
  assign bus.cfg_block = busy_q;
  assign bus.done      = done_q;
  assign bus.l1_idx    = l1_idx_q;
  assign bus.l1_rd     = l1_rd_q;
  assign bus.l2_set    = l2_set_q;
  assign bus.l2_ent    = l2_ent_q;
  assign bus.l2_rd     = l2_rd_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      min_q    <= '0;
      max_q    <= '0;
      l1_idx_q <= '0;
      l2_set_q <= '0;
      l2_ent_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      l1_rd_q  <= 1'b0;
      l2_rd_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      min_q    <= min_d;
      max_q    <= max_d;
      l1_idx_q <= l1_idx_d;
      l2_set_q <= l2_set_d;
      l2_ent_q <= l2_ent_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      l1_rd_q  <= l1_rd_d;
      l2_rd_q  <= l2_rd_d;
    end
  end

  // Walk order: L1 slices, then L2 entries within a set, then the next set.
  always_comb begin
    state_d  = state_q;
    min_d    = min_q;
    max_d    = max_q;
    l1_idx_d = l1_idx_q;
    l2_set_d = l2_set_q;
    l2_ent_d = l2_ent_q;

    case (state_q)
      IDLE: begin
        if (bus.req) begin
          min_d    = bus.inv_min;
          max_d    = bus.inv_max;
          l1_idx_d = '0;
          state_d  = L1_RD;
        end
      end
      L1_RD:  state_d = L1_CHK;
      L1_CHK: begin
        if (l1_idx_q == L1_LAST) begin
          l2_set_d = '0;
          l2_ent_d = '0;
          state_d  = L2_RD;
        end else begin
          l1_idx_d = l1_idx_q + L1_IW'(1);
          state_d  = L1_RD;
        end
      end
      L2_RD:  state_d = L2_CHK;
      L2_CHK: begin
        if (l2_ent_q == ENT_LAST) begin
          l2_ent_d = '0;
          if (l2_set_q == SET_LAST) begin
            state_d = FIN;
          end else begin
            l2_set_d = l2_set_q + SET_W'(1);
            state_d  = L2_RD;
          end
        end else begin
          l2_ent_d = l2_ent_q + ENT_W'(1);
          state_d  = L2_RD;
        end
      end
      FIN: begin
        l1_idx_d = '0;
        l2_set_d = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Registered outputs follow the state being entered.
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == FIN);
    l1_rd_d = (state_d == L1_RD);
    l2_rd_d = (state_d == L2_RD);
  end
endmodule
